// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the VRAM arbiter slice.
package vram_pkg;

  localparam int VRAM_DEPTH_W    = 12;
  localparam int VRAM_DATA_W     = 19;
  localparam int VRAM_STARVE_MAX = 15;

  typedef enum logic {
    IDLE   = 1'b0,
    ISSUED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vram_starve_cnt.sv
// Saturating counter of consecutive cycles a pending CPU request lost to VGA.
module vram_starve_cnt #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != CW'(MAX))) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA reads have fixed priority, the CPU gets a
// req/ack handshake and a guaranteed slot after STARVE_MAX denied cycles.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DEPTH_W    = VRAM_DEPTH_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int STARVE_MAX = VRAM_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [DEPTH_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              vga_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              ram_we,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  arb_state_e        state;
  logic              issued_we;
  logic              vga_valid_q;
  logic              vga_miss_q;
  logic [DATA_W-1:0] vga_hold;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic cpu_grant;
  logic vga_grant;
  logic starve_inc;
  logic starve_clr;
  logic at_max;

  // Address and data bits the arbiter deliberately ignores.
  logic unused_bits;
  assign unused_bits = ^{ram_dout[31:DATA_W], cpu_addr[31:DEPTH_W+2], cpu_addr[1:0]};

  always_comb begin
    cpu_grant  = !rst && (state == IDLE) && cpu_req && (!vga_req || at_max);
    vga_grant  = !rst && vga_req && !cpu_grant;
    starve_inc = (state == IDLE) && cpu_req && vga_req && !cpu_grant;
    starve_clr = cpu_grant || !cpu_req;
  end

  vram_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst) begin
      if (cpu_grant) begin
        ram_we   = cpu_we;
        ram_addr = {{(30-DEPTH_W){1'b0}}, cpu_addr[DEPTH_W+1:2], 2'b00};
        ram_din  = cpu_wdata;
      end else begin
        ram_addr = {{(30-DEPTH_W){1'b0}}, vga_addr, 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issued_we   <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_miss_q  <= 1'b0;
      vga_hold    <= '0;
      cpu_rdata_q <= '0;
    end else begin
      vga_valid_q <= vga_grant;
      vga_miss_q  <= vga_req && cpu_grant;
      if (vga_valid_q) begin
        vga_hold <= ram_dout[DATA_W-1:0];
      end
      case (state)
        IDLE: begin
          if (cpu_grant) begin
            state     <= ISSUED;
            issued_we <= cpu_we;
          end
        end
        ISSUED: begin
          state <= IDLE;
          if (!issued_we) begin
            cpu_rdata_q <= ram_dout[DATA_W-1:0];
          end
        end
      endcase
    end
  end

  // Outputs are forced low while rst is high so an in-flight read never surfaces.
  assign vga_valid = vga_valid_q && !rst;
  assign vga_miss  = vga_miss_q && !rst;
  assign vga_data  = rst ? '0 : (vga_valid_q ? ram_dout[DATA_W-1:0] : vga_hold);
  assign cpu_ack   = (state == ISSUED) && !rst;
  assign cpu_rdata = rst ? '0 : {{(32-DATA_W){1'b0}}, cpu_rdata_q};

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a behavioural memory/arbitration model
// is stepped once per cycle alongside directed and randomized scenarios.
module tb_vram_arbiter;

  localparam int DEPTH_W    = 12;
  localparam int DATA_W     = 19;
  localparam int STARVE_MAX = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              vga_req;
  logic [DEPTH_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              vga_miss;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ack;
  logic              ram_we;
  logic [31:0]       ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  vram_arbiter #(
    .DEPTH_W    (DEPTH_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_data  (vga_data),
    .vga_valid (vga_valid),
    .vga_miss  (vga_miss),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  // Synchronous single-port VRAM holding full 32-bit words.
  logic [31:0] vram [0:4095];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) vram[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      vram[ram_addr[13:2]] <= ram_din;
    end
    ram_dout <= vram[ram_addr[13:2]];
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [0:4095];
  bit                m_valid, m_miss, m_busy, m_pend_we;
  logic [DATA_W-1:0] m_vga_rd, m_vga_hold, m_pend_rd;
  logic [31:0]       m_rdata;
  int                m_wait;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit obs_ack, obs_valid, obs_miss;

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic drive_cycle(input bit r, input bit vr, input logic [11:0] va, input bit cr,
                             input bit cw, input logic [31:0] ca, input logic [31:0] cwd);
    bit                g_cpu, g_vga, e_we, e_valid, e_miss, e_ack;
    logic [31:0]       e_addr, e_din, e_rdata;
    logic [DATA_W-1:0] e_vdata;
    logic [11:0]       word;
    @(negedge clk);
    rst = r; vga_req = vr; vga_addr = va; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd;
    #1;
    word    = ca[13:2];
    e_valid = !r && m_valid;
    e_miss  = !r && m_miss;
    e_ack   = !r && m_busy;
    e_vdata = r ? '0 : (m_valid ? m_vga_rd : m_vga_hold);
    e_rdata = r ? 32'h0 : m_rdata;
    g_cpu   = !r && cr && !m_busy && (!vr || m_wait >= STARVE_MAX);
    g_vga   = !r && vr && !g_cpu;
    e_we    = g_cpu && cw;
    e_addr  = r ? 32'h0 : (g_cpu ? {18'h0, word, 2'b00} : {18'h0, va, 2'b00});
    e_din   = g_cpu ? cwd : 32'h0;

    n_vec++; if (vga_valid !== e_valid) begin n_err++; $display("FAIL vga_valid cycle %0d: got %b want %b", cyc, vga_valid, e_valid); end
    n_vec++; if (vga_miss !== e_miss) begin n_err++; $display("FAIL vga_miss cycle %0d: got %b want %b", cyc, vga_miss, e_miss); end
    n_vec++; if (cpu_ack !== e_ack) begin n_err++; $display("FAIL cpu_ack cycle %0d: got %b want %b", cyc, cpu_ack, e_ack); end
    n_vec++; if (vga_data !== e_vdata) begin n_err++; $display("FAIL vga_data cycle %0d: got %h want %h", cyc, vga_data, e_vdata); end
    n_vec++; if (cpu_rdata !== e_rdata) begin n_err++; $display("FAIL cpu_rdata cycle %0d: got %h want %h", cyc, cpu_rdata, e_rdata); end
    n_vec++; if (ram_we !== e_we) begin n_err++; $display("FAIL ram_we cycle %0d: got %b want %b", cyc, ram_we, e_we); end
    n_vec++; if (ram_addr !== e_addr) begin n_err++; $display("FAIL ram_addr cycle %0d: got %h want %h", cyc, ram_addr, e_addr); end
    n_vec++; if (ram_din !== e_din) begin n_err++; $display("FAIL ram_din cycle %0d: got %h want %h", cyc, ram_din, e_din); end

    if (r) begin
      m_valid = 0; m_miss = 0; m_busy = 0; m_wait = 0;
      m_vga_hold = '0; m_rdata = '0;
    end else begin
      if (m_valid) m_vga_hold = m_vga_rd;
      if (m_busy && !m_pend_we) m_rdata = {13'h0, m_pend_rd};
      m_vga_rd = ref_mem[va];
      if (g_cpu) begin
        m_pend_we = cw;
        if (cw) ref_mem[word] = cwd[DATA_W-1:0];
        else    m_pend_rd = ref_mem[word];
      end
      if (g_cpu || !cr)                                    m_wait = 0;
      else if (!m_busy && vr && m_wait < STARVE_MAX)       m_wait++;
      m_valid = g_vga;
      m_miss  = vr && g_cpu;
      m_busy  = g_cpu;
    end
    obs_ack = cpu_ack; obs_valid = vga_valid; obs_miss = vga_miss;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    drive_cycle(1, 1, 12'h005, 1, 1, 32'h40, 32'hDEAD_BEEF);
    drive_cycle(1, 1, 12'h005, 1, 1, 32'h40, 32'hDEAD_BEEF);
    n_vec++; if (ram_we !== 1'b0 || cpu_ack !== 1'b0 || vga_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got we=%b ack=%b valid=%b want 0 0 0", ram_we, cpu_ack, vga_valid);
    end
    drive_cycle(0, 0, '0, 0, 0, '0, '0);
    n_vec++; if (obs_ack !== 1'b0 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: got ack=%b valid=%b want 0 0", obs_ack, obs_valid);
    end
  endtask

  task automatic test_write_read();
    drive_cycle(0, 0, '0, 1, 1, 32'h0000_0010, 32'h0007_FFFF);
    n_vec++; if (ram_we !== 1'b1 || ram_addr !== 32'h10) begin
      n_err++; $display("FAIL wr_issue: got we=%b addr=%h want 1 00000010", ram_we, ram_addr);
    end
    drive_cycle(0, 0, '0, 1, 1, 32'h0000_0010, 32'h0007_FFFF);
    n_vec++; if (obs_ack !== 1'b1) begin n_err++; $display("FAIL wr_ack: got %b want 1", obs_ack); end
    drive_cycle(0, 0, '0, 1, 0, 32'h0000_0010, '0);
    drive_cycle(0, 0, '0, 1, 0, 32'h0000_0010, '0);
    idle(1);
    n_vec++; if (cpu_rdata !== 32'h0007_FFFF) begin
      n_err++; $display("FAIL rd_back: got %h want 0007ffff", cpu_rdata);
    end
  endtask

  task automatic test_zero_ext();
    drive_cycle(0, 0, '0, 1, 1, 32'h0000_0124, 32'hFFFF_FFFF);
    drive_cycle(0, 0, '0, 1, 1, 32'h0000_0124, 32'hFFFF_FFFF);
    drive_cycle(0, 0, '0, 1, 0, 32'h0000_0124, '0);
    drive_cycle(0, 0, '0, 1, 0, 32'h0000_0124, '0);
    idle(1);
    n_vec++; if (cpu_rdata !== 32'h0007_FFFF) begin
      n_err++; $display("FAIL zero_ext: got %h want 0007ffff", cpu_rdata);
    end
  endtask

  task automatic test_vga_priority();
    bit acked = 0;
    int n_ack = 0, n_miss = 0, n_grant = 0, n_valid = 0;
    int ack_at = -1, miss_at = -1, grant_at = -1;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(0, 1, 12'(i), !acked, 0, 32'hF000_2000, '0);
      if (ram_addr === 32'h0000_2000) begin n_grant++; grant_at = i; end
      if (obs_ack)   begin n_ack++; ack_at = i; acked = 1; end
      if (obs_miss)  begin n_miss++; miss_at = i; end
      if (obs_valid) n_valid++;
    end
    idle(2);
    n_vec++; if (n_grant != 1 || grant_at != 15) begin
      n_err++; $display("FAIL starve_grant: got %0d grants at %0d want 1 at 15", n_grant, grant_at);
    end
    n_vec++; if (n_miss != 1 || miss_at != 16) begin
      n_err++; $display("FAIL starve_miss: got %0d misses at %0d want 1 at 16", n_miss, miss_at);
    end
    n_vec++; if (n_ack != 1 || ack_at != 16) begin
      n_err++; $display("FAIL starve_ack: got %0d acks at %0d want 1 at 16", n_ack, ack_at);
    end
    n_vec++; if (n_valid != 18) begin
      n_err++; $display("FAIL starve_valid_count: got %0d want 18", n_valid);
    end
  endtask

  task automatic test_held_req();
    int n_ack = 0, first = -1, second = -1;
    for (int i = 0; i < 7; i++) begin
      drive_cycle(0, 0, '0, (i < 4), 0, 32'h0000_0100, '0);
      if (obs_ack) begin
        n_ack++;
        if (first < 0) first = i; else second = i;
      end
    end
    n_vec++; if (n_ack != 2 || first != 1 || second != 3) begin
      n_err++; $display("FAIL held_req: got %0d acks at %0d,%0d want 2 at 1,3", n_ack, first, second);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd;
    int          n_valid = 0;
    wd = $urandom;
    drive_cycle(0, 0, '0, 1, 1, 32'h0000_02AC, wd);
    drive_cycle(0, 1, 12'h0AB, 1, 1, 32'h0000_02AC, wd);
    idle(1);
    n_vec++; if (vga_valid !== 1'b1 || vga_data !== wd[DATA_W-1:0]) begin
      n_err++; $display("FAIL wr_then_vga: got valid=%b data=%h want 1 %h", vga_valid, vga_data, wd[DATA_W-1:0]);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(0, 1, 12'($urandom_range(0, 4095)), 0, 0, '0, '0);
      if (i > 0 && obs_valid) n_valid++;
    end
    idle(1);
    if (obs_valid) n_valid++;
    n_vec++; if (n_valid != 8) begin
      n_err++; $display("FAIL vga_burst: got %0d valids want 8", n_valid);
    end
  endtask

  task automatic test_reset_mid_read();
    drive_cycle(0, 0, '0, 1, 0, 32'h0000_0040, '0);
    drive_cycle(1, 0, '0, 1, 0, 32'h0000_0040, '0);
    n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rst_mid_ack_n1: got %b want 0", cpu_ack); end
    drive_cycle(0, 0, '0, 0, 0, '0, '0);
    n_vec++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rst_mid_ack_n2: got %b want 0", cpu_ack); end
    drive_cycle(0, 1, 12'h033, 0, 0, '0, '0);
    drive_cycle(1, 0, '0, 0, 0, '0, '0);
    n_vec++; if (vga_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", vga_valid); end
    drive_cycle(0, 0, '0, 0, 0, '0, '0);
    n_vec++; if (vga_valid !== 1'b0) begin n_err++; $display("FAIL rst_after_valid: got %b want 0", vga_valid); end
    drive_cycle(0, 0, '0, 1, 1, 32'h0000_0044, 32'h1234_5678);
    n_vec++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL rst_idle_grant: got %b want 1", ram_we); end
    drive_cycle(0, 0, '0, 1, 1, 32'h0000_0044, 32'h1234_5678);
    n_vec++; if (obs_ack !== 1'b1) begin n_err++; $display("FAIL rst_idle_ack: got %b want 1", obs_ack); end
    idle(1);
  endtask

  task automatic test_random();
    bit          act = 0, cw = 0, vr;
    logic [31:0] ca = '0, cwd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!act && $urandom_range(0, 2) == 0) begin
        act     = 1;
        cw      = 1'($urandom_range(0, 1));
        ca      = $urandom;
        ca[13:2] = 12'($urandom_range(0, 15));
        cwd     = $urandom;
      end
      vr = ((i % 100) < 40) ? 1'b1 : 1'($urandom_range(0, 1));
      drive_cycle(0, vr, 12'($urandom_range(0, 15)), act, cw, ca, cwd);
      if (obs_ack) act = 0;
    end
    idle(2);
  endtask

  initial begin
    rst = 1'b1; vga_req = 1'b0; vga_addr = '0; cpu_req = 1'b0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      logic [31:0] w;
      w = init_word(i);
      ref_mem[i] = w[DATA_W-1:0];
    end
    m_valid = 0; m_miss = 0; m_busy = 0; m_pend_we = 0; m_wait = 0;
    m_vga_rd = '0; m_vga_hold = '0; m_pend_rd = '0; m_rdata = '0;

    test_reset();
    test_write_read();
    test_zero_ext();
    test_vga_priority();
    test_held_req();
    test_back_to_back();
    test_reset_mid_read();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
